// File: rtl/ads131_pkg.sv
// Shared command codes, FSM encodings and input-pin indices for the ADS131 SPI responder.
package ads131_pkg;

  localparam logic [15:0] CMD_NULL   = 16'h0000;
  localparam logic [15:0] CMD_UNLOCK = 16'h0655;
  localparam logic [15:0] CMD_LOCK   = 16'h0555;
  localparam logic [15:0] RESP_READY = 16'hFF04;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_RST_HOLD = 2'd3
  } state_e;

  localparam int SIG_SCLK  = 0;
  localparam int SIG_CS    = 1;
  localparam int SIG_MOSI  = 2;
  localparam int SIG_RESET = 3;

  // Idle pin levels: SCLK low, CS high, MOSI low, RESET high.
  localparam logic [3:0] PINS_IDLE = 4'b1010;

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchroniser plus previous-value flop per pin; exposes synced level and edge strobes.
module spi_input_sync #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic         system_clock,
  input  logic         reset_n,
  input  logic [N-1:0] async_pins,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  logic [N-1:0] sync_p0;
  logic [N-1:0] sync_p1;
  logic [N-1:0] prev_p2;

  // Reset to idle pin levels so leaving reset never fakes an edge.
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
      prev_p2 <= RST_VAL;
    end else begin
      sync_p0 <= async_pins;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~prev_p2;
  assign fall  = ~sync_p1 & prev_p2;

endmodule

// File: rtl/ads131_spi_responder.sv
// SPI mode-1 responder emulating the ADS131A0X command/status handshake for loopback of the SPI master.
module ads131_spi_responder
  import ads131_pkg::*;
#(
  parameter int          WORD_BITS   = 32,
  parameter logic [15:0] STATUS_WORD = 16'h2220,
  parameter int          CNT_W       = 6
) (
  input  logic                 system_clock,
  input  logic                 reset_n,
  input  logic                 SPI_SCLK,
  input  logic                 SPI_CS,
  input  logic                 SPI_MOSI,
  input  logic                 SPI_RESET,
  output logic                 SPI_MISO,
  output logic [WORD_BITS-1:0] rx_word,
  output logic                 rx_valid,
  output logic                 rx_error,
  output logic                 unlocked,
  output logic [1:0]           state
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORD_BITS + 1);

  logic [3:0] pin_lvl, pin_rise, pin_fall;

  spi_input_sync #(
    .N       (4),
    .RST_VAL (PINS_IDLE)
  ) u_sync (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .async_pins   ({SPI_RESET, SPI_MOSI, SPI_CS, SPI_SCLK}),
    .level        (pin_lvl),
    .rise         (pin_rise),
    .fall         (pin_fall)
  );

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_lvl, rst_lvl;
  assign sclk_rise = pin_rise[SIG_SCLK];
  assign sclk_fall = pin_fall[SIG_SCLK];
  assign cs_rise   = pin_rise[SIG_CS];
  assign cs_fall   = pin_fall[SIG_CS];
  assign mosi_lvl  = pin_lvl[SIG_MOSI];
  assign rst_lvl   = pin_lvl[SIG_RESET];

  logic sync_unused;
  assign sync_unused = &{1'b0, pin_lvl[SIG_SCLK], pin_lvl[SIG_CS],
                         pin_rise[SIG_MOSI], pin_fall[SIG_MOSI],
                         pin_rise[SIG_RESET], pin_fall[SIG_RESET]};

  state_e               fsm_state;
  logic [WORD_BITS-1:0] tx_sr;
  logic [WORD_BITS-1:0] rx_sr;
  logic [CNT_W-1:0]     bit_cnt;
  logic [15:0]          next_resp;
  logic [15:0]          cmd;

  assign cmd   = rx_sr[WORD_BITS-1 -: 16];
  assign state = fsm_state;

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      fsm_state <= ST_IDLE;
      SPI_MISO  <= 1'b0;
      rx_word   <= '0;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
      unlocked  <= 1'b0;
      next_resp <= RESP_READY;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      // ADC reset pin overrides any frame in flight; the frame is dropped without an error strobe.
      if (!rst_lvl) begin
        fsm_state <= ST_RST_HOLD;
        unlocked  <= 1'b0;
        next_resp <= RESP_READY;
        SPI_MISO  <= 1'b0;
      end else begin
        case (fsm_state)
          ST_IDLE: begin
            SPI_MISO <= 1'b0;
            if (cs_fall) begin
              fsm_state <= ST_SHIFT;
              tx_sr     <= {next_resp, {(WORD_BITS-16){1'b0}}};
              rx_sr     <= '0;
              bit_cnt   <= '0;
            end
          end
          ST_SHIFT: begin
            // CS edge wins over a coincident SCLK edge, so a trailing SCLK fall never adds a bit.
            if (cs_rise) begin
              fsm_state <= ST_COMMIT;
            end else if (sclk_rise) begin
              SPI_MISO <= tx_sr[WORD_BITS-1];
              tx_sr    <= {tx_sr[WORD_BITS-2:0], 1'b0};
            end else if (sclk_fall) begin
              rx_sr <= {rx_sr[WORD_BITS-2:0], mosi_lvl};
              if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_COMMIT: begin
            fsm_state <= ST_IDLE;
            SPI_MISO  <= 1'b0;
            if (bit_cnt == CNT_FULL) begin
              rx_word  <= rx_sr;
              rx_valid <= 1'b1;
              // Response is queued for the next frame, mirroring the device's one-frame latency.
              if (!unlocked) begin
                if (cmd == CMD_UNLOCK) begin
                  unlocked  <= 1'b1;
                  next_resp <= CMD_UNLOCK;
                end else begin
                  next_resp <= RESP_READY;
                end
              end else begin
                case (cmd)
                  CMD_NULL:   next_resp <= STATUS_WORD;
                  CMD_UNLOCK: next_resp <= CMD_UNLOCK;
                  CMD_LOCK: begin
                    unlocked  <= 1'b0;
                    next_resp <= CMD_LOCK;
                  end
                  default:    next_resp <= 16'h0000;
                endcase
              end
            end else begin
              rx_error <= 1'b1;
            end
          end
          ST_RST_HOLD: begin
            SPI_MISO  <= 1'b0;
            fsm_state <= ST_IDLE;
          end
          default: fsm_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ads131_spi_responder.sv
// Directed bench acting as SPI master against the ADS131 responder.
module tb_ads131_spi_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        rst_pin = 1'b1;
  logic        miso;
  logic [31:0] rx_word;
  logic        rx_valid;
  logic        rx_error;
  logic        unlocked;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;
  int nvalid = 0;
  int nerr   = 0;

  always #10 clk = ~clk;

  ads131_spi_responder #(
    .WORD_BITS   (32),
    .STATUS_WORD (16'h2220),
    .CNT_W       (6)
  ) dut (
    .system_clock (clk),
    .reset_n      (reset_n),
    .SPI_SCLK     (sclk),
    .SPI_CS       (cs),
    .SPI_MOSI     (mosi),
    .SPI_RESET    (rst_pin),
    .SPI_MISO     (miso),
    .rx_word      (rx_word),
    .rx_valid     (rx_valid),
    .rx_error     (rx_error),
    .unlocked     (unlocked),
    .state        (state)
  );

  always @(negedge clk) begin
    if (rx_valid) nvalid++;
    if (rx_error) nerr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCLK period: drive MOSI with the rise, sample MISO just before the fall.
  task automatic sclk_cycle(input logic b, inout logic [31:0] m);
    sclk = 1'b1;
    mosi = b;
    wait_clk(HALF);
    m = {m[30:0], miso};
    sclk = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic frame(input logic [31:0] tx, input int nbits, output logic [31:0] m);
    logic [31:0] acc;
    acc = '0;
    cs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++)
      sclk_cycle((i < 32) ? tx[5'(31 - i)] : 1'b0, acc);
    cs = 1'b1;
    mosi = 1'b0;
    wait_clk(10);
    m = acc;
  endtask

  initial begin
    logic [31:0] m;
    int v0, e0;

    wait_clk(5);
    check("reset_state", 32'(state), 32'd0);
    check("reset_unlocked", 32'(unlocked), 32'd0);
    check("reset_rx_word", rx_word, 32'h0);
    check("reset_miso", 32'(miso), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    reset_n = 1'b1;
    wait_clk(5);

    // 1: NULL while locked
    frame(32'h0000_0000, 32, m);
    check("t1_miso", m, 32'hFF04_0000);
    check("t1_nvalid", 32'(nvalid), 32'd1);
    check("t1_rx_word", rx_word, 32'h0);
    frame(32'h0000_0000, 32, m);
    check("t1_miso_locked", m, 32'hFF04_0000);
    check("t1_unlocked", 32'(unlocked), 32'd0);

    // 2: unlock then NULL twice
    frame(32'h0655_0101, 32, m);
    check("t2_rx_word", rx_word, 32'h0655_0101);
    check("t2_unlocked", 32'(unlocked), 32'd1);
    frame(32'h0000_0000, 32, m);
    check("t2_miso_unlock_echo", m, 32'h0655_0000);
    frame(32'h0000_0000, 32, m);
    check("t2_miso_status", m, 32'h2220_0000);

    // 3: lock
    frame(32'h0555_0000, 32, m);
    check("t3_miso_status", m, 32'h2220_0000);
    check("t3_unlocked", 32'(unlocked), 32'd0);
    frame(32'h0000_0000, 32, m);
    check("t3_miso_lock_echo", m, 32'h0555_0000);

    // 4: short and overrun frames while unlocked
    frame(32'h0655_ABCD, 32, m);
    check("t4_unlock_rx", rx_word, 32'h0655_ABCD);
    v0 = nvalid;
    e0 = nerr;
    frame(32'hAAAA_AAAA, 20, m);
    check("t4_short_err", 32'(nerr - e0), 32'd1);
    frame(32'h5555_5555, 33, m);
    check("t4_over_err", 32'(nerr - e0), 32'd2);
    check("t4_no_valid", 32'(nvalid - v0), 32'd0);
    check("t4_rx_word_kept", rx_word, 32'h0655_ABCD);
    check("t4_still_unlocked", 32'(unlocked), 32'd1);
    frame(32'h0000_0000, 32, m);
    check("t4_resp_kept", m, 32'h0655_0000);

    // 5: ADC reset pin mid-frame
    v0 = nvalid;
    e0 = nerr;
    m = '0;
    cs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 10; i++) sclk_cycle(1'b1, m);
    rst_pin = 1'b0;
    wait_clk(10);
    check("t5_state_hold", 32'(state), 32'd3);
    check("t5_unlocked", 32'(unlocked), 32'd0);
    check("t5_miso_low", 32'(miso), 32'd0);
    rst_pin = 1'b1;
    wait_clk(10);
    check("t5_idle_cs_low", 32'(state), 32'd0);
    check("t5_no_err", 32'(nerr - e0), 32'd0);
    check("t5_no_valid", 32'(nvalid - v0), 32'd0);
    cs = 1'b1;
    mosi = 1'b0;
    wait_clk(10);
    frame(32'h0000_0000, 32, m);
    check("t5_miso_ready", m, 32'hFF04_0000);

    // 6: CS rise coincident with a trailing SCLK fall after bit 32
    v0 = nvalid;
    e0 = nerr;
    m = '0;
    cs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] pat;
      pat = 32'hC3A5_5A3C;
      sclk_cycle(pat[5'(31 - i)], m);
    end
    sclk = 1'b1;
    mosi = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
    cs = 1'b1;
    wait_clk(10);
    mosi = 1'b0;
    check("t6_miso", m, 32'hFF04_0000);
    check("t6_valid", 32'(nvalid - v0), 32'd1);
    check("t6_no_err", 32'(nerr - e0), 32'd0);
    check("t6_rx_word", rx_word, 32'hC3A5_5A3C);
    check("t6_state_idle", 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ads131_spi_responder.md
Name: ads131_spi_responder

Overview:
- Behavioural SPI responder, synthesisable, standing in for the ADS131A0X ADC at the far end of the SPI master link.
- Used for on-FPGA loopback and bench verification of the master.
- Oversamples SCLK/CS/MOSI/RESET on the 50 MHz system clock. Deserialises command words on MOSI and serialises status/echo words on MISO (SPI mode 1).
- Tracks the device lock/unlock state and presents each received word to fabric with a valid pulse.

Parameters:
- WORD_BITS, 32, bits per SPI frame; the command/response field is the upper 16 bits and the lower bits transmit as 0.
- STATUS_WORD, 16'h2220, response to NULL while unlocked.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WORD_BITS+1.

Ports:
- system_clock  in  1  50 MHz system clock
- reset_n  in  1  synchronous active-low reset
- SPI_SCLK  in  1  SPI clock from master, asynchronous, CPOL=0
- SPI_CS  in  1  chip select, active-low, asynchronous
- SPI_MOSI  in  1  master-out data, asynchronous
- SPI_RESET  in  1  ADC reset pin, active-low, asynchronous
- SPI_MISO  out  1  slave-out data
- rx_word  out  WORD_BITS  last complete received frame
- rx_valid  out  1  one-cycle pulse when rx_word updates
- rx_error  out  1  one-cycle pulse on aborted or overrun frame
- unlocked  out  1  device unlocked flag
- state  out  2  debug: current FSM state

Behaviour:
- Clocking and reset: one clock (system_clock). reset_n is synchronous and active-low.
- Reset values:
  - SPI_MISO, rx_word, rx_valid, rx_error, unlocked = 0; state = IDLE.
  - Next response = 16'hFF04 (READY). bit counter = 0.
- Input path:
  - Each of SCLK/CS/MOSI/RESET passes through a 2-flop synchroniser, then a registered previous-value flop for edge detection.
  - Pin-to-edge-detect latency is 3 system_clock cycles.
  - Required: each SCLK high/low phase is at least 4 system_clock cycles. The master runs at about 6 cycles per phase.
- FSM states: IDLE(0), SHIFT(1), COMMIT(2), RST_HOLD(3).
  - IDLE -> SHIFT on synced CS falling edge.
    - Load tx shifter with {next_resp, zeros}; clear rx shifter and bit counter.
  - SHIFT, SCLK rising edge: SPI_MISO <= tx_sr[MSB]; tx_sr shifts left, zero-filled.
  - SHIFT, SCLK falling edge: rx_sr <= {rx_sr, MOSI_sync}; bit counter increments, saturating at WORD_BITS+1.
  - SHIFT -> COMMIT on synced CS rising edge.
  - COMMIT (one cycle) -> IDLE; SPI_MISO <= 0. Then:
    - If bit counter == WORD_BITS: rx_word <= rx_sr; rx_valid = 1; decode rx_sr[WORD_BITS-1 -: 16].
    - Otherwise (short frame or overrun): rx_error = 1; rx_word, lock state and next_resp unchanged.
  - Any state -> RST_HOLD while synced SPI_RESET is 0.
    - Frame abandoned silently (no rx_error).
    - unlocked <= 0; next_resp <= 16'hFF04; SPI_MISO <= 0.
  - RST_HOLD -> IDLE when SPI_RESET returns to 1. A frame starts only on a fresh CS falling edge, so CS already low at release is ignored until it toggles.
- Command decode, in COMMIT:
  - Locked:
    - UNLOCK 16'h0655: unlocked <= 1; next_resp <= 16'h0655.
    - All other commands: next_resp <= 16'hFF04.
  - Unlocked:
    - NULL 16'h0000: next_resp <= STATUS_WORD.
    - UNLOCK 16'h0655: next_resp <= 16'h0655.
    - LOCK 16'h0555: unlocked <= 0; next_resp <= 16'h0555.
    - Other: next_resp <= 16'h0000.
  - A response always appears in the frame after the command (one-frame latency), matching device behaviour.
- Simultaneous events (same sampling cycle):
  - SPI_RESET low beats everything.
  - CS edge beats SCLK edges; the SCLK edge is ignored.
  - reset_n beats all.
- SCLK edges while CS is high are ignored.
- SPI_MISO is 0 whenever not in SHIFT.

Decomposition:
- Package ads131_pkg holds:
  - CMD_NULL = 16'h0000, CMD_UNLOCK = 16'h0655, CMD_LOCK = 16'h0555, RESP_READY = 16'hFF04.
  - FSM state encodings.
- Sub-module spi_input_sync: 4-bit 2-flop synchroniser plus edge detector. Outputs are the synced level, rise and fall per signal.
- Top-level module: FSM, shifters, counter and decode.

Test Plan:
1. Reset, then one 32-bit frame MOSI=0x00000000 -> rx_valid pulse, rx_word=0; MISO shows 0xFF040000; next frame still returns 0xFF040000 (locked).
2. Frame 0x06550101, then NULL, then NULL -> second frame MISO=0x06550000 and unlocked=1; third frame MISO=0x22200000.
3. While unlocked, send 0x05550000, then NULL -> second frame MISO=0x05550000; unlocked=0 after the first frame's COMMIT.
4. CS raised after 20 SCLK falls, then CS raised after 33 SCLK falls -> each gives one rx_error pulse, no rx_valid, rx_word unchanged, next response unchanged.
5. Unlock, pulse SPI_RESET low mid-frame (bit 10) -> state=3, no rx_error, unlocked=0; after release and a fresh CS cycle with NULL, MISO=0xFF040000.
6. CS rising edge coincident with SCLK falling edge on bit 32 -> frame commits with exactly 32 bits and no extra shift.
